// File: rtl/midi_msg_parser.sv
// Takes the received MIDI byte stream and builds complete messages from it, with running status, system common and SysEx handling.
// Real-time bytes are passed out on their own channel and leave the message parsing untouched.
//
// state   | meaning
// S_IDLE  | no message pending; running status may be valid
// S_DATA1 | status latched, waiting for first data byte
// S_DATA2 | first data byte stored, waiting for second
// S_SYSEX | inside F0..F7, data bytes ignored
module midi_msg_parser #(
  parameter bit RUNNING_STATUS_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_strobe_in,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       msg_valid,
  output logic [7:0] rt_byte,
  output logic       rt_valid,
  output logic       sysex_active,
  output logic [7:0] drop_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA1 = 2'd1;
  localparam logic [1:0] S_DATA2 = 2'd2;
  localparam logic [1:0] S_SYSEX = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] status_q, status_d;
  logic       two_q, two_d;
  logic       rs_valid_q, rs_valid_d;
  logic [6:0] data1_q, data1_d;
  logic [7:0] msg_status_q, msg_status_d;
  logic [6:0] msg_data1_q, msg_data1_d;
  logic [6:0] msg_data2_q, msg_data2_d;
  logic       msg_valid_q, msg_valid_d;
  logic [7:0] rt_byte_q, rt_byte_d;
  logic       rt_valid_q, rt_valid_d;
  logic       sysex_q, sysex_d;
  logic [7:0] drop_q, drop_d;

  logic       emit;
  logic [7:0] emit_status;
  logic [6:0] emit_d1;
  logic [6:0] emit_d2;
  logic       drop_inc;
  logic       take_data1;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    two_d       = two_q;
    rs_valid_d  = rs_valid_q;
    data1_d     = data1_q;
    rt_byte_d   = rt_byte_q;
    rt_valid_d  = 1'b0;
    sysex_d     = sysex_q;
    emit        = 1'b0;
    emit_status = status_q;
    emit_d1     = 7'd0;
    emit_d2     = 7'd0;
    drop_inc    = 1'b0;
    // Running status re-enters the first-data-byte path from IDLE.
    take_data1  = (state_q == S_DATA1) ||
                  ((state_q == S_IDLE) && RUNNING_STATUS_EN && rs_valid_q);

    if (byte_strobe_in) begin
      if (byte_in >= 8'hF8) begin
        rt_byte_d  = byte_in;
        rt_valid_d = 1'b1;
      end else if (byte_in[7]) begin
        // Any non-real-time status aborts whatever was pending.
        sysex_d    = 1'b0;
        state_d    = S_IDLE;
        rs_valid_d = 1'b0;
        if (byte_in <= 8'hEF) begin
          status_d   = byte_in;
          two_d      = (byte_in[7:5] != 3'b110);
          rs_valid_d = 1'b1;
          state_d    = S_DATA1;
        end else begin
          case (byte_in)
            8'hF0: begin
              sysex_d = 1'b1;
              state_d = S_SYSEX;
            end
            8'hF1, 8'hF3: begin
              status_d = byte_in;
              two_d    = 1'b0;
              state_d  = S_DATA1;
            end
            8'hF2: begin
              status_d = byte_in;
              two_d    = 1'b1;
              state_d  = S_DATA1;
            end
            8'hF6: begin
              emit        = 1'b1;
              emit_status = byte_in;
            end
            8'hF4, 8'hF5: drop_inc = 1'b1;
            default: ;
          endcase
        end
      end else if (state_q == S_DATA2) begin
        emit    = 1'b1;
        emit_d1 = data1_q;
        emit_d2 = byte_in[6:0];
        state_d = S_IDLE;
      end else if (take_data1) begin
        if (two_q) begin
          data1_d = byte_in[6:0];
          state_d = S_DATA2;
        end else begin
          emit    = 1'b1;
          emit_d1 = byte_in[6:0];
          state_d = S_IDLE;
        end
      end else if (state_q == S_IDLE) begin
        drop_inc = 1'b1;
      end
    end

    msg_valid_d  = emit;
    msg_status_d = emit ? emit_status : msg_status_q;
    msg_data1_d  = emit ? emit_d1 : msg_data1_q;
    msg_data2_d  = emit ? emit_d2 : msg_data2_q;
    drop_d       = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      status_q     <= 8'd0;
      two_q        <= 1'b0;
      rs_valid_q   <= 1'b0;
      data1_q      <= 7'd0;
      msg_status_q <= 8'd0;
      msg_data1_q  <= 7'd0;
      msg_data2_q  <= 7'd0;
      msg_valid_q  <= 1'b0;
      rt_byte_q    <= 8'd0;
      rt_valid_q   <= 1'b0;
      sysex_q      <= 1'b0;
      drop_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      two_q        <= two_d;
      rs_valid_q   <= rs_valid_d;
      data1_q      <= data1_d;
      msg_status_q <= msg_status_d;
      msg_data1_q  <= msg_data1_d;
      msg_data2_q  <= msg_data2_d;
      msg_valid_q  <= msg_valid_d;
      rt_byte_q    <= rt_byte_d;
      rt_valid_q   <= rt_valid_d;
      sysex_q      <= sysex_d;
      drop_q       <= drop_d;
    end
  end

  assign msg_status   = msg_status_q;
  assign msg_data1    = msg_data1_q;
  assign msg_data2    = msg_data2_q;
  assign msg_valid    = msg_valid_q;
  assign rt_byte      = rt_byte_q;
  assign rt_valid     = rt_valid_q;
  assign sysex_active = sysex_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: directed MIDI byte sequences plus a random byte stream.
// Every cycle's outputs are compared against a message-level model that queues the data bytes.
module tb_midi_msg_parser;

  logic       clock;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_strobe_in;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic       msg_valid;
  logic [7:0] rt_byte;
  logic       rt_valid;
  logic       sysex_active;
  logic [7:0] drop_count;

  int tests = 0;
  int fails = 0;

  midi_msg_parser #(.RUNNING_STATUS_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_strobe_in(byte_strobe_in),
    .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .msg_valid(msg_valid), .rt_byte(rt_byte), .rt_valid(rt_valid),
    .sysex_active(sysex_active), .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: a message is a status plus a queue of data bytes; it is emitted when the queue reaches the needed length.
  bit         m_collect;
  logic [7:0] m_cur;
  logic [7:0] m_rs;
  bit         m_rs_ok;
  bit         m_sx;
  logic [6:0] m_pend[$];
  int         m_drops;
  logic [7:0] e_status;
  logic [6:0] e_d1, e_d2;
  bit         e_mv, e_rv;
  logic [7:0] e_rt;

  function automatic int data_len(logic [7:0] s);
    if (s >= 8'hC0 && s <= 8'hDF) return 1;
    if (s == 8'hF1 || s == 8'hF3) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_collect = 0; m_cur = 0; m_rs = 0; m_rs_ok = 0; m_sx = 0;
    m_pend.delete(); m_drops = 0;
    e_status = 0; e_d1 = 0; e_d2 = 0; e_mv = 0; e_rv = 0; e_rt = 0;
  endtask

  task automatic model_emit(logic [7:0] s, logic [6:0] a, logic [6:0] b);
    e_mv = 1; e_status = s; e_d1 = a; e_d2 = b;
  endtask

  task automatic model_drop();
    if (m_drops < 255) m_drops++;
  endtask

  task automatic model_byte(logic [7:0] b);
    e_mv = 0; e_rv = 0;
    if (b >= 8'hF8) begin
      e_rv = 1; e_rt = b;
    end else if (b[7]) begin
      m_collect = 0; m_pend.delete(); m_sx = 0;
      if (b <= 8'hEF) begin
        m_cur = b; m_collect = 1; m_rs = b; m_rs_ok = 1;
      end else begin
        m_rs_ok = 0;
        case (b)
          8'hF0: m_sx = 1;
          8'hF1, 8'hF2, 8'hF3: begin m_cur = b; m_collect = 1; end
          8'hF6: model_emit(b, 0, 0);
          8'hF4, 8'hF5: model_drop();
          default: ;
        endcase
      end
    end else if (!m_sx) begin
      if (!m_collect && m_rs_ok) begin
        m_cur = m_rs; m_collect = 1;
      end
      if (!m_collect) model_drop();
      else begin
        m_pend.push_back(b[6:0]);
        if (m_pend.size() == data_len(m_cur)) begin
          model_emit(m_cur, m_pend[0], (m_pend.size() > 1) ? m_pend[1] : 7'd0);
          m_collect = 0; m_pend.delete();
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("msg_valid", {31'd0, msg_valid}, {31'd0, e_mv});
    chk("rt_valid", {31'd0, rt_valid}, {31'd0, e_rv});
    chk("msg_status", {24'd0, msg_status}, {24'd0, e_status});
    chk("msg_data1", {25'd0, msg_data1}, {25'd0, e_d1});
    chk("msg_data2", {25'd0, msg_data2}, {25'd0, e_d2});
    chk("rt_byte", {24'd0, rt_byte}, {24'd0, e_rt});
    chk("sysex_active", {31'd0, sysex_active}, {31'd0, m_sx});
    chk("drop_count", {24'd0, drop_count}, m_drops);
  endtask

  // Called at a negedge; drives one cycle and checks outputs just after the sampling edge.
  task automatic step(bit stb, logic [7:0] b);
    byte_strobe_in = stb;
    byte_in = b;
    if (stb) model_byte(b);
    else begin e_mv = 0; e_rv = 0; end
    @(posedge clock); #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic send(logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1; byte_strobe_in = 1'b0; byte_in = 8'h00;
    @(posedge clock); #1;
    model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'($urandom_range(0, 127));
    if (r < 80) return 8'($urandom_range(8'h80, 8'hEF));
    if (r < 88) return 8'($urandom_range(8'hF8, 8'hFF));
    return 8'($urandom_range(8'hF0, 8'hF7));
  endfunction

  initial begin
    reset = 1'b1; byte_strobe_in = 1'b0; byte_in = 8'h00;
    model_reset();
    @(negedge clock);
    do_reset();

    // note on, then running status
    send(8'h90); send(8'h3C); send(8'h64); idle(1);
    send(8'h3E); send(8'h40); idle(2);
    // program change with running status
    send(8'hC5); send(8'h07); send(8'h08); idle(1);
    // real-time in the middle of a message
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64); idle(1);
    // velocity zero passes through unchanged
    send(8'h90); send(8'h3C); send(8'h00); idle(1);
    // abort by new status
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h07); send(8'h7F); idle(1);
    // system common and tune request
    send(8'hF2); send(8'h11); send(8'h22); send(8'h33);
    send(8'hF3); send(8'h05); send(8'hF6); send(8'hF4); send(8'hF5); idle(1);

    do_reset();
    // sysex then a stray data byte
    send(8'hF0); send(8'h01); send(8'hFE); send(8'h02); send(8'hF7); send(8'h45); idle(1);
    chk("sysex_drop_one", {24'd0, drop_count}, 32'd1);

    // reset mid-message must not produce a pulse
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64); idle(2);

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) send(8'h11);
    chk("drop_saturated", {24'd0, drop_count}, 32'd255);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) send(rand_byte());
      else step(1'b0, 8'($urandom));
      if (i == 1500) do_reset();
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
